// File: rtl/wave_capture_if.sv
// Sample-stream, display-status and RAM-write signals
// between wave_capture and its neighbours.
interface wave_capture_if #(
  parameter int SAMPLE_W = 16,
  parameter int OUT_W    = 8,
  parameter int ADDR_W   = 9
);
  logic                new_sample_ready;
  logic [SAMPLE_W-1:0] new_sample_in;
  logic                wave_display_idle;
  logic [ADDR_W-1:0]   write_address;
  logic                write_enable;
  logic [OUT_W-1:0]    write_sample;
  logic                read_index;

  modport master (
    input  new_sample_ready,
    input  new_sample_in,
    input  wave_display_idle,
    output write_address,
    output write_enable,
    output write_sample,
    output read_index
  );

  modport slave (
    output new_sample_ready,
    output new_sample_in,
    output wave_display_idle,
    input  write_address,
    input  write_enable,
    input  write_sample,
    input  read_index
  );
endinterface

// File: rtl/wave_capture.sv
// Zero-crossing triggered capture of 256 offset-binary
// samples into the idle half of a double-buffered RAM.
module wave_capture #(
  parameter int SAMPLE_W = 16,
  parameter int OUT_W    = 8,
  parameter int ADDR_W   = 9
) (
  input logic           clk,
  input logic           reset,
  wave_capture_if.master bus
);
  localparam int IDX_W = ADDR_W - 1;

  typedef enum logic [1:0] {
    S_ARMED,
    S_ACTIVE,
    S_WAIT
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  count;
  logic              prev_neg;
  logic              read_index;
  logic              write_enable;
  logic [ADDR_W-1:0] write_address;
  logic [OUT_W-1:0]  write_sample;

  logic [OUT_W-1:0]  top_bits;
  logic [OUT_W-1:0]  conv;
  logic              cur_neg;
  logic              crossing;

  assign top_bits = bus.new_sample_in[SAMPLE_W-1 -: OUT_W];
  assign conv     = {~top_bits[OUT_W-1], top_bits[OUT_W-2:0]};
  assign cur_neg  = bus.new_sample_in[SAMPLE_W-1];
  assign crossing = prev_neg & ~cur_neg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_ARMED;
      count         <= '0;
      prev_neg      <= 1'b0;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
    end else begin
      write_enable <= 1'b0;
      unique case (state)
        S_ARMED: begin
          if (bus.new_sample_ready) begin
            prev_neg <= cur_neg;
            if (crossing) begin
              write_enable  <= 1'b1;
              write_address <= {~read_index, {IDX_W{1'b0}}};
              write_sample  <= conv;
              count         <= IDX_W'(1);
              state         <= S_ACTIVE;
            end
          end
        end
        S_ACTIVE: begin
          if (bus.new_sample_ready) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, count};
            write_sample  <= conv;
            count         <= count + 1'b1;
            if (&count)
              state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Flip buffers only while the display is between frames.
          if (bus.wave_display_idle) begin
            read_index <= ~read_index;
            prev_neg   <= 1'b0;
            state      <= S_ARMED;
          end
        end
        default: state <= S_ARMED;
      endcase
    end
  end

  assign bus.read_index    = read_index;
  assign bus.write_enable  = write_enable;
  assign bus.write_address = write_address;
  assign bus.write_sample  = write_sample;
endmodule

// File: tb/tb_wave_capture.sv
// Directed test of wave_capture: trigger, frame fill,
// buffer flip, reset abort and held strobe.
module tb_wave_capture;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  wave_capture_if #(.SAMPLE_W(16), .OUT_W(8), .ADDR_W(9)) bus ();

  wave_capture #(.SAMPLE_W(16), .OUT_W(8), .ADDR_W(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wr(input logic       we,
                                     input logic [8:0] a,
                                     input logic [7:0] d);
    return {14'd0, we, a, d};
  endfunction

  function automatic logic [31:0] obs_wr();
    return {14'd0, bus.write_enable, bus.write_address,
            bus.write_sample};
  endfunction

  // Pulse one strobe; returns at the negedge where the
  // registered result of that strobe is visible.
  task automatic strobe(input logic [15:0] v);
    @(negedge clk);
    bus.new_sample_ready = 1'b1;
    bus.new_sample_in    = v;
    @(negedge clk);
    bus.new_sample_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.new_sample_ready  = 1'b0;
    bus.new_sample_in     = '0;
    bus.wave_display_idle = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_out", obs_wr(), wr(1'b0, 9'h000, 8'h00));
    chk("rst_ri", 32'(bus.read_index), 32'd0);

    strobe(16'h1000);
    chk("pos_pos_a", 32'(bus.write_enable), 32'd0);
    strobe(16'h2000);
    chk("pos_pos_b", 32'(bus.write_enable), 32'd0);
    chk("pos_ri", 32'(bus.read_index), 32'd0);
    chk("pos_addr", 32'(bus.write_address), 32'h000);

    strobe(16'hF000);
    chk("neg_nowr", 32'(bus.write_enable), 32'd0);
    strobe(16'h0100);
    chk("trig_wr", obs_wr(), wr(1'b1, 9'h100, 8'h81));
    @(negedge clk);
    chk("trig_1cyc", 32'(bus.write_enable), 32'd0);

    for (int i = 1; i < 256; i++) begin
      strobe(16'h8000);
      chk("fill_wr", obs_wr(), wr(1'b1, 9'(9'h100 + i), 8'h00));
    end

    strobe(16'h8000);
    chk("wait_ign_a", 32'(bus.write_enable), 32'd0);
    strobe(16'h0000);
    chk("wait_ign_b", 32'(bus.write_enable), 32'd0);

    repeat (10) @(negedge clk);
    chk("wait_hold_ri", 32'(bus.read_index), 32'd0);
    bus.wave_display_idle = 1'b1;
    @(negedge clk);
    bus.wave_display_idle = 1'b0;
    chk("flip_ri", 32'(bus.read_index), 32'd1);

    strobe(16'hFFFF);
    chk("rearm_nowr", 32'(bus.write_enable), 32'd0);
    strobe(16'h7FFF);
    chk("half0_wr", obs_wr(), wr(1'b1, 9'h000, 8'hFF));

    for (int i = 1; i < 100; i++) begin
      strobe(16'h1234);
      chk("half0_fill", obs_wr(), wr(1'b1, 9'(i), 8'h92));
    end
    chk("half0_ri", 32'(bus.read_index), 32'd1);

    // reset collides with a strobe: reset must win
    @(negedge clk);
    reset = 1'b1;
    bus.new_sample_ready = 1'b1;
    bus.new_sample_in    = 16'h4000;
    @(negedge clk);
    reset = 1'b0;
    bus.new_sample_ready = 1'b0;
    chk("abort_out", obs_wr(), wr(1'b0, 9'h000, 8'h00));
    chk("abort_ri", 32'(bus.read_index), 32'd0);

    bus.wave_display_idle = 1'b1;
    strobe(16'h8000);
    bus.wave_display_idle = 1'b0;
    chk("armed_idle_ri", 32'(bus.read_index), 32'd0);
    chk("armed_neg", 32'(bus.write_enable), 32'd0);

    @(negedge clk);
    bus.new_sample_ready = 1'b1;
    bus.new_sample_in    = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held_wr", obs_wr(), wr(1'b1, 9'(9'h100 + i), 8'h80));
    end
    bus.new_sample_ready = 1'b0;
    @(negedge clk);
    chk("held_end", 32'(bus.write_enable), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Writer side of the double-buffered sample RAM that wave_display reads through read_address/read_index.
- Watches the audio sample stream and arms on a positive-going zero crossing.
- Writes 256 consecutive 8-bit offset-binary samples into the half of the RAM not currently being displayed.
- Flips read_index once the display reports idle, so a new frame is shown only between frames.

Parameters:
- SAMPLE_W, 16, width of incoming signed two's-complement audio sample.
- OUT_W, 8, width of stored sample (top OUT_W bits of the input, converted to offset binary).
- ADDR_W, 9, RAM address width; MSB selects the buffer half, low ADDR_W-1 bits are the sample index (256 entries per half).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid this cycle.
- new_sample_in  input  SAMPLE_W  signed sample.
- wave_display_idle  input  1  high while wave_display is outside the active drawing region.
- write_address  output  ADDR_W  RAM write address = {~read_index, count}.
- write_enable  output  1  one-cycle RAM write strobe.
- write_sample  output  OUT_W  data to write.
- read_index  output  1  buffer half wave_display must read; the capture side writes the other half.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset), sampled on the rising clk edge.
- Reset values: state=ARMED, read_index=0, write_enable=0, write_address=0, write_sample=0, count=0, prev_sample=0.
- All outputs are registered.
- Latency: write_enable/address/sample are asserted the cycle after the accepted new_sample_ready, for exactly one cycle.
- Sample conversion: write_sample = new_sample_in[SAMPLE_W-1 -: OUT_W] with its MSB inverted (i.e. +128 offset).
  - 0x8000 -> 0x00
  - 0x0000 -> 0x80
  - 0x7FFF -> 0xFF
- ARMED:
  - On each new_sample_ready, compare against prev_sample, then load prev_sample <= new_sample_in.
  - Trigger condition: prev_sample MSB=1 (negative) and new_sample_in MSB=0 (>=0).
  - On trigger, the triggering sample is written at index 0, count becomes 1, state -> ACTIVE.
  - Otherwise no write occurs.
- ACTIVE:
  - Each new_sample_ready writes at index count, then count increments.
  - The write at index 255 moves state -> WAIT, and count wraps to 0.
  - No zero-crossing check is made in this state.
- WAIT:
  - new_sample_ready is ignored; no writes occur.
  - On the first cycle with wave_display_idle=1: read_index toggles, prev_sample clears to 0, state -> ARMED.
- wave_display_idle is ignored in ARMED and ACTIVE.
- read_index changes only on the WAIT->ARMED transition.
- write_address MSB is always ~read_index, so the writer never touches the half being read.
- new_sample_ready held high for multiple cycles counts as one sample per cycle; callers must pulse it.
- Reset mid-capture abandons the partial frame and returns to the reset values (read_index back to 0). Partial RAM contents are left as-is.
- Simultaneous new_sample_ready and reset: reset wins; no write.
- Sample exactly 0 after a negative sample triggers. Positive -> negative or positive -> positive does not.

Test Plan:
- Reset for 2 cycles, then strobe samples 0x1000, 0x2000 -> no write_enable; read_index=0; write_address=0.
- Strobes 0xF000 then 0x0100 -> one cycle after the second strobe: write_enable=1, write_address=0x100, write_sample=0x81; state ACTIVE.
- Continue with 255 more strobes, value 0x8000 each -> 255 single-cycle writes, addresses 0x101..0x1FF, write_sample=0x00; then further strobes produce no write (WAIT).
- In WAIT hold wave_display_idle=0 for 10 cycles -> read_index stays 0. Raise idle -> read_index=1 the next cycle. Then 0xFFFF followed by 0x7FFF -> write at address 0x000 with data 0xFF.
- Mid-ACTIVE after 100 writes, assert reset -> outputs return to reset values, read_index=0. A subsequent crossing restarts at address 0x100.
- Strobe held high 3 cycles with the 0x0000 crossing sample after 0x8000 -> 3 writes at indices 0, 1, 2, data 0x80.
